// File: rtl/chuchu_ckpt_pkg.sv
// Shared sizes, FSM encoding and helpers for the checkpoint page controller.
package chuchu_ckpt_pkg;

  localparam int NUM_PAGES = 8;
  localparam int PAGE_W    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    SETTLE  = 2'd2
  } ckpt_state_t;

  function automatic logic [PAGE_W:0] popcount(input logic [NUM_PAGES-1:0] v);
    logic [PAGE_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      c = c + {{PAGE_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/chuchu_ckpt_age.sv
// Age matrix: older_q[i][j]=1 when live page i was allocated before live page j.
module chuchu_ckpt_age
  import chuchu_ckpt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [PAGE_W-1:0]    alloc_page,
  input  logic [NUM_PAGES-1:0] live,
  input  logic [NUM_PAGES-1:0] free_mask,
  input  logic [PAGE_W-1:0]    query_page,
  output logic [NUM_PAGES-1:0] younger_mask
);

  logic [NUM_PAGES-1:0] older_q [NUM_PAGES];
  logic [NUM_PAGES-1:0] older_d [NUM_PAGES];

  always_comb begin
    for (int i = 0; i < NUM_PAGES; i++) begin
      older_d[i] = older_q[i];
    end
    if (alloc_en) begin
      for (int k = 0; k < NUM_PAGES; k++) begin
        older_d[k][alloc_page] = live[k];
      end
      older_d[alloc_page] = '0;
    end
    // Frees win over a same-cycle alloc so a page freed now never ranks as older.
    for (int i = 0; i < NUM_PAGES; i++) begin
      if (free_mask[i]) begin
        older_d[i] = '0;
        for (int j = 0; j < NUM_PAGES; j++) begin
          older_d[j][i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PAGES; i++) begin
        older_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PAGES; i++) begin
        older_q[i] <= older_d[i];
      end
    end
  end

  assign younger_mask = older_q[query_page];

endmodule

// File: rtl/chuchu_ckpt_ctrl.sv
// Checkpoint page controller: grants snapshot pages to branches, frees them on
// resolution and sequences restore + squash on a mispredict.
module chuchu_ckpt_ctrl
  import chuchu_ckpt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  // Handshake: a grant happens in a cycle where br_alloc_valid & br_alloc_ready;
  // ready depends only on registered state, never on valid or resolve inputs.
  input  logic                 br_alloc_valid,
  output logic                 br_alloc_ready,
  output logic [PAGE_W-1:0]    br_alloc_page,
  input  logic                 resolve_valid,
  input  logic [PAGE_W-1:0]    resolve_page,
  input  logic                 resolve_mispredict,
  output logic                 save_state,
  output logic [PAGE_W-1:0]    save_page,
  output logic                 restore_state,
  output logic [PAGE_W-1:0]    restore_page,
  output logic                 recover_busy,
  output logic [NUM_PAGES-1:0] flush_mask,
  output logic [PAGE_W:0]      pages_in_use,
  output ckpt_state_t          dbg_state
);

  ckpt_state_t          state_q, state_d;
  logic [NUM_PAGES-1:0] in_use_q, in_use_d;
  logic [NUM_PAGES-1:0] kill_q, kill_d;
  logic [PAGE_W-1:0]    rest_page_q, rest_page_d;
  logic                 save_state_q, save_state_d;
  logic [PAGE_W-1:0]    save_page_q, save_page_d;
  logic [PAGE_W:0]      pages_q, pages_d;

  logic [PAGE_W-1:0]    grant_page;
  logic                 free_hit;
  logic                 resolve_live, mispredict_take, correct_free;
  logic                 alloc_fire, alloc_keep;
  logic [NUM_PAGES-1:0] free_mask;
  logic [NUM_PAGES-1:0] younger_mask;

  always_comb begin
    free_hit   = 1'b0;
    grant_page = '0;
    for (int i = NUM_PAGES - 1; i >= 0; i--) begin
      if (!in_use_q[i]) begin
        free_hit   = 1'b1;
        grant_page = PAGE_W'(i);
      end
    end
  end

  assign br_alloc_ready  = (state_q == IDLE) && free_hit;
  assign br_alloc_page   = grant_page;
  assign alloc_fire      = br_alloc_valid && br_alloc_ready;
  assign resolve_live    = resolve_valid && in_use_q[resolve_page];
  assign mispredict_take = (state_q == IDLE) && resolve_live && resolve_mispredict;
  assign correct_free    = resolve_live && !resolve_mispredict;
  // A grant racing a mispredict is younger than the bad branch: it is squashed.
  assign alloc_keep      = alloc_fire && !mispredict_take;

  always_comb begin
    state_d       = state_q;
    rest_page_d   = rest_page_q;
    kill_d        = '0;
    free_mask     = '0;
    restore_state = 1'b0;
    recover_busy  = 1'b0;
    flush_mask    = '0;
    if (correct_free) begin
      free_mask[resolve_page] = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (mispredict_take) begin
          state_d     = RESTORE;
          rest_page_d = resolve_page;
          if (alloc_fire) begin
            kill_d[grant_page] = 1'b1;
          end
        end
      end
      RESTORE: begin
        restore_state = 1'b1;
        recover_busy  = 1'b1;
        flush_mask    = (in_use_q & younger_mask) | kill_q;
        free_mask     = free_mask | flush_mask;
        free_mask[rest_page_q] = 1'b1;
        state_d       = SETTLE;
      end
      SETTLE: begin
        recover_busy = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_use_d = in_use_q & ~free_mask;
    if (alloc_keep) begin
      in_use_d[grant_page] = 1'b1;
    end
    pages_d      = popcount(in_use_d);
    save_state_d = alloc_keep;
    save_page_d  = alloc_keep ? grant_page : save_page_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      in_use_q     <= '0;
      kill_q       <= '0;
      rest_page_q  <= '0;
      save_state_q <= 1'b0;
      save_page_q  <= '0;
      pages_q      <= '0;
    end else begin
      state_q      <= state_d;
      in_use_q     <= in_use_d;
      kill_q       <= kill_d;
      rest_page_q  <= rest_page_d;
      save_state_q <= save_state_d;
      save_page_q  <= save_page_d;
      pages_q      <= pages_d;
    end
  end

  chuchu_ckpt_age u_age (
    .clk          (clk),
    .reset        (reset),
    .alloc_en     (alloc_keep),
    .alloc_page   (grant_page),
    .live         (in_use_q),
    .free_mask    (free_mask),
    .query_page   (rest_page_q),
    .younger_mask (younger_mask)
  );

  assign save_state   = save_state_q;
  assign save_page    = save_page_q;
  assign restore_page = rest_page_q;
  assign pages_in_use = pages_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_chuchu_ckpt_ctrl.sv
// Bench for chuchu_ckpt_ctrl: directed scenarios plus random traffic against an
// age-ordered list model, with strobes checked through expected queues.
module tb_chuchu_ckpt_ctrl;
  import chuchu_ckpt_pkg::*;

  logic                 clk;
  logic                 reset;
  logic                 br_alloc_valid;
  logic                 br_alloc_ready;
  logic [PAGE_W-1:0]    br_alloc_page;
  logic                 resolve_valid;
  logic [PAGE_W-1:0]    resolve_page;
  logic                 resolve_mispredict;
  logic                 save_state;
  logic [PAGE_W-1:0]    save_page;
  logic                 restore_state;
  logic [PAGE_W-1:0]    restore_page;
  logic                 recover_busy;
  logic [NUM_PAGES-1:0] flush_mask;
  logic [PAGE_W:0]      pages_in_use;
  ckpt_state_t          dbg_state;

  chuchu_ckpt_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .br_alloc_valid     (br_alloc_valid),
    .br_alloc_ready     (br_alloc_ready),
    .br_alloc_page      (br_alloc_page),
    .resolve_valid      (resolve_valid),
    .resolve_page       (resolve_page),
    .resolve_mispredict (resolve_mispredict),
    .save_state         (save_state),
    .save_page          (save_page),
    .restore_state      (restore_state),
    .restore_page       (restore_page),
    .recover_busy       (recover_busy),
    .flush_mask         (flush_mask),
    .pages_in_use       (pages_in_use),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int                          live_q[$];   // live pages, oldest first
  int                          m_phase;     // 0 idle, 1 restoring, 2 settling
  int                          m_p;
  logic [NUM_PAGES-1:0]        m_flush;
  logic [PAGE_W-1:0]           exp_q[$];    // expected save_page per strobe
  logic [PAGE_W+NUM_PAGES-1:0] rest_exp_q[$];

  int check_cnt = 0;
  int fail_cnt  = 0;

  function automatic bit is_live(input int p);
    foreach (live_q[i]) if (live_q[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lowest_free();
    for (int p = 0; p < NUM_PAGES; p++) if (!is_live(p)) return p;
    return 0;
  endfunction

  task automatic remove_page(input int p);
    for (int i = 0; i < live_q.size(); i++) begin
      if (live_q[i] == p) begin
        live_q.delete(i);
        return;
      end
    end
  endtask

  task automatic model_reset();
    live_q.delete();
    exp_q.delete();
    rest_exp_q.delete();
    m_phase = 0;
    m_p     = 0;
    m_flush = '0;
  endtask

  // Applies the rules for the inputs consumed at this rising edge.
  task automatic model_step();
    bit                   acc, mis, found;
    int                   g, old_phase;
    logic [NUM_PAGES-1:0] fl;
    old_phase = m_phase;
    mis       = 1'b0;
    acc       = (old_phase == 0) && (live_q.size() < NUM_PAGES) && br_alloc_valid;
    g         = lowest_free();
    if (resolve_valid && is_live(int'(resolve_page))) begin
      if (!resolve_mispredict) begin
        remove_page(int'(resolve_page));
      end else if (old_phase == 0) begin
        fl    = '0;
        found = 1'b0;
        foreach (live_q[i]) begin
          if (found) fl = fl | (NUM_PAGES'(1) << live_q[i]);
          if (live_q[i] == int'(resolve_page)) found = 1'b1;
        end
        if (acc) fl = fl | (NUM_PAGES'(1) << g);
        rest_exp_q.push_back({resolve_page, fl});
        m_p     = int'(resolve_page);
        m_flush = fl;
        m_phase = 1;
        mis     = 1'b1;
      end
    end
    if (acc && !mis) begin
      live_q.push_back(g);
      exp_q.push_back(PAGE_W'(g));
    end
    if (old_phase == 1) begin
      for (int p = 0; p < NUM_PAGES; p++) if (m_flush[p]) remove_page(p);
      remove_page(m_p);
      m_phase = 2;
    end else if (old_phase == 2) begin
      m_phase = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor_cycle();
    bit                          exp_ready;
    logic [PAGE_W-1:0]           ep;
    logic [PAGE_W+NUM_PAGES-1:0] er;
    ckpt_state_t                 es;
    exp_ready = (m_phase == 0) && (live_q.size() < NUM_PAGES);
    es = (m_phase == 0) ? IDLE : (m_phase == 1) ? RESTORE : SETTLE;
    check("alloc_ready", 32'(br_alloc_ready), 32'(exp_ready));
    if (exp_ready) check("alloc_page", 32'(br_alloc_page), 32'(lowest_free()));
    check("pages_in_use", 32'(pages_in_use), 32'(live_q.size()));
    check("recover_busy", 32'(recover_busy), 32'(m_phase != 0));
    check("state", 32'(dbg_state), 32'(es));
    if (exp_q.size() > 0) begin
      ep = exp_q.pop_front();
      check("save_state", 32'(save_state), 32'(1));
      check("save_page", 32'(save_page), 32'(ep));
    end else begin
      check("save_state_quiet", 32'(save_state), 32'(0));
    end
    if (rest_exp_q.size() > 0) begin
      er = rest_exp_q.pop_front();
      check("restore_state", 32'(restore_state), 32'(1));
      check("restore_page", 32'(restore_page), 32'(er[PAGE_W+NUM_PAGES-1:NUM_PAGES]));
      check("flush_mask", 32'(flush_mask), 32'(er[NUM_PAGES-1:0]));
    end else begin
      check("restore_quiet", 32'(restore_state), 32'(0));
      check("flush_quiet", 32'(flush_mask), 32'(0));
    end
    check("strobe_overlap", 32'(save_state & restore_state), 32'(0));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) monitor_cycle();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit av, input bit rv, input logic [PAGE_W-1:0] rp, input bit rm);
    @(negedge clk);
    #1;
    br_alloc_valid     = av;
    resolve_valid      = rv;
    resolve_page       = rp;
    resolve_mispredict = rm;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_save_state", 32'(save_state), 32'(0));
    check("rst_save_page", 32'(save_page), 32'(0));
    check("rst_restore_state", 32'(restore_state), 32'(0));
    check("rst_restore_page", 32'(restore_page), 32'(0));
    check("rst_recover_busy", 32'(recover_busy), 32'(0));
    check("rst_flush_mask", 32'(flush_mask), 32'(0));
    check("rst_pages_in_use", 32'(pages_in_use), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset              = 1'b0;
    br_alloc_valid     = 1'b0;
    resolve_valid      = 1'b0;
    resolve_page       = '0;
    resolve_mispredict = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_ready", 32'(br_alloc_ready), 32'(1));
    check("rel_page", 32'(br_alloc_page), 32'(0));
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          idx;
    logic [PAGE_W-1:0] rp;
    reset              = 1'b0;
    br_alloc_valid     = 1'b0;
    resolve_valid      = 1'b0;
    resolve_page       = '0;
    resolve_mispredict = 1'b0;
    model_reset();
    do_reset();

    // Three grants: pages 0,1,2 with one strobe each.
    alloc_n(3);
    idle(2);

    // Fill up, stall while full, free page 5 and take it again.
    alloc_n(6);
    cycle(1'b0, 1'b1, 3'd5, 1'b0);
    alloc_n(1);
    idle(2);

    // Mispredict page 1 with pages 0..4 live.
    do_reset();
    alloc_n(5);
    cycle(1'b0, 1'b1, 3'd1, 1'b1);
    idle(4);

    // Mispredict on page 2 racing the grant of page 3.
    do_reset();
    alloc_n(3);
    cycle(1'b1, 1'b1, 3'd2, 1'b1);
    idle(2);
    alloc_n(2);
    idle(1);

    // Ages out of index order: page 0 is younger than pages 1 and 2.
    do_reset();
    alloc_n(3);
    cycle(1'b0, 1'b1, 3'd0, 1'b0);
    alloc_n(1);
    cycle(1'b0, 1'b1, 3'd2, 1'b1);
    idle(3);

    // Correct resolve during recovery, ignored mispredict during recovery.
    alloc_n(4);
    cycle(1'b0, 1'b1, 3'd1, 1'b1);
    cycle(1'b1, 1'b1, 3'd0, 1'b0);
    cycle(1'b1, 1'b1, 3'd2, 1'b1);
    idle(2);

    // Reset while RESTORE is being presented.
    do_reset();
    alloc_n(4);
    cycle(1'b0, 1'b1, 3'd1, 1'b1);
    @(negedge clk);
    #3;
    reset              = 1'b0;
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(br_alloc_ready), 32'(1));
    check("abort_page", 32'(br_alloc_page), 32'(0));
    idle(3);

    // Random traffic.
    for (int n = 0; n < 2500; n++) begin
      if (live_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        idx = int'($urandom_range(0, 1000)) % live_q.size();
        rp  = PAGE_W'(live_q[idx]);
      end else begin
        rp = PAGE_W'($urandom_range(0, NUM_PAGES - 1));
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rp,
            $urandom_range(0, 4) == 0);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

endmodule
